player_sprite_drawer: RTL

Downstream of the player position stage. It consumes the player's x/y position and turns it into a stream of single-pixel writes for the VGA adapter (160x120 framebuffer). On each frame tick it erases the sprite at the previously drawn position with the background colour, then redraws it at the current position with the foreground colour. One pixel is written per clock.

---
 rtl/player_sprite_drawer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/player_sprite_drawer.sv
// player_sprite_drawer
//   Turns the player's top-left position into a stream of single-pixel writes
//   for a 160x120 VGA framebuffer adapter. On each frame tick, the block first
//   erases the sprite at the previously drawn position using BG_COLOUR. It then
//   redraws the sprite at the current position using FG_COLOUR. One pixel is
//   written per clock, scanning in row-major order.
//
//   Optional build macro: SKIP_UNCHANGED_EN
//     When this macro is defined, a start at the same position as the last
//     drawn sprite skips both passes. The sequence goes straight to the finish
//     cycle.
//
// Ports
//   clk      : rising-edge system clock
//   reset_n  : synchronous, active-HIGH reset (the name is historical)
//   start    : 1-cycle frame tick; accepted only while idle and not busy
//   x_pos    : player x (top-left corner of the sprite), 8 bits
//   y_pos    : player y (top-left corner of the sprite), 7 bits
//   x_out    : pixel x sent to the adapter
//   y_out    : pixel y sent to the adapter
//   colour   : pixel colour
//   plot     : write strobe; high when x_out/y_out/colour form a valid pixel
//   busy     : high from the accepted start through the done cycle
//   done     : 1-cycle pulse when a sequence completes
module player_sprite_drawer #(
  parameter int         SPRITE_W  = 4,
  parameter int         SPRITE_H  = 4,
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] x_pos,
  input  logic [6:0] y_pos,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, FIN} state_t;

  state_t     state;
  logic [7:0] cur_x, prev_x;
  logic [6:0] cur_y, prev_y;
  logic       prev_valid;
  // 4-bit counters cover sprite sizes 1..16
  logic [3:0] dx, dy;

  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] wide_x;   // one bit wider than the port so off-screen pixels are visible
  logic [7:0] wide_y;
  logic       on_screen;
  logic       row_end, pass_end;
  logic       same_pos;

  always_comb begin
    base_x = cur_x;
    base_y = cur_y;
    if (state == ERASE) begin
      base_x = prev_x;
      base_y = prev_y;
    end
    wide_x    = {1'b0, base_x} + {5'b0, dx};
    wide_y    = {1'b0, base_y} + {4'b0, dy};
    on_screen = (wide_x < 9'(SCREEN_W)) && (wide_y < 8'(SCREEN_H));
    row_end   = (dx == 4'(SPRITE_W - 1));
    pass_end  = row_end && (dy == 4'(SPRITE_H - 1));
  end

`ifdef SKIP_UNCHANGED_EN
  assign same_pos = prev_valid && (x_pos == prev_x) && (y_pos == prev_y);
`else
  assign same_pos = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state      <= IDLE;
      cur_x      <= '0;
      cur_y      <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
      prev_valid <= 1'b0;
      dx         <= '0;
      dy         <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          busy <= 1'b0;
          // busy is still high for one cycle after FIN (the done cycle),
          // so a start coinciding with done is dropped here
          if (start && !busy) begin
            cur_x <= x_pos;
            cur_y <= y_pos;
            dx    <= '0;
            dy    <= '0;
            busy  <= 1'b1;
            if (same_pos)        state <= FIN;
            else if (prev_valid) state <= ERASE;
            else                 state <= DRAW;
          end
        end
        ERASE, DRAW: begin
          x_out  <= wide_x[7:0];
          y_out  <= wide_y[6:0];
          colour <= (state == ERASE) ? BG_COLOUR : FG_COLOUR;
          // clipped pixels still consume a cycle, so the timing is fixed
          plot   <= on_screen;
          if (row_end) begin
            dx <= '0;
            if (pass_end) begin
              dy    <= '0;
              state <= (state == ERASE) ? DRAW : FIN;
            end else begin
              dy <= dy + 4'd1;
            end
          end else begin
            dx <= dx + 4'd1;
          end
        end
        FIN: begin
          plot       <= 1'b0;
          done       <= 1'b1;
          prev_x     <= cur_x;
          prev_y     <= cur_y;
          prev_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
